seg7_result_display: RTL and testbench

- Consumes the processor's 16-bit `result` bus and shows it as 4 hex digits on a common-anode, multiplexed 7-segment display.
- Sits directly downstream of the RISC-V processor top on the board.
- Captures values on a load strobe and applies them only at frame boundaries, so digits never tear.
- Scans one digit at a time, with a guard interval against ghosting and optional leading-zero blanking.

---
 rtl/seg7_result_display.sv | 139 +++++++++++++
 tb/tb_seg7_result_display.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_result_display.sv
// Four-digit multiplexed hex display for the processor result bus.
// New values are captured on load and swapped in only at frame boundaries, so digits never tear.
module seg7_result_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [1:0]  digit_idx,
  output logic        frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD);
  localparam logic [6:0]       SEG_OFF   = 7'h7F;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  logic [15:0]      disp_q, disp_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic             frame_tick_q, frame_tick_d;

  logic             slot_end;
  logic             boundary;
  logic [3:0]       nibble;
  logic             blanked;

  function automatic logic [6:0] hex_font(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign slot_end = (cnt_q == CNT_MAX);
  assign boundary = slot_end && (idx_q == 2'd3);

  always_comb begin
    nibble  = disp_q[3:0];
    blanked = 1'b0;
    case (idx_q)
      2'd0: nibble = disp_q[3:0];
      2'd1: begin
        nibble  = disp_q[7:4];
        blanked = blank_en && (disp_q[15:4] == 12'h000);
      end
      2'd2: begin
        nibble  = disp_q[11:8];
        blanked = blank_en && (disp_q[15:8] == 8'h00);
      end
      default: begin
        nibble  = disp_q[15:12];
        blanked = blank_en && (disp_q[15:12] == 4'h0);
      end
    endcase
  end

  // A load on the boundary cycle bypasses pending so the newest value is never held back a frame.
  always_comb begin
    cnt_d           = slot_end ? '0 : cnt_q + 1'b1;
    idx_d           = slot_end ? idx_q + 2'd1 : idx_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    disp_d          = disp_q;
    if (load) begin
      pending_d = value;
      if (boundary) begin
        disp_d          = value;
        pending_valid_d = 1'b0;
      end else begin
        pending_valid_d = 1'b1;
      end
    end else if (boundary && pending_valid_q) begin
      disp_d          = pending_q;
      pending_valid_d = 1'b0;
    end

    digit_idx_d  = idx_q;
    an_d         = (cnt_q < GUARD_END) ? 4'hF : ~(4'b0001 << idx_q);
    seg_d        = blanked ? SEG_OFF : hex_font(nibble);
    frame_tick_d = boundary;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q           <= '0;
      idx_q           <= 2'd0;
      pending_q       <= 16'h0000;
      pending_valid_q <= 1'b0;
      disp_q          <= 16'h0000;
      an_q            <= 4'hF;
      seg_q           <= SEG_OFF;
      digit_idx_q     <= 2'd0;
      frame_tick_q    <= 1'b0;
    end else begin
      cnt_q           <= cnt_d;
      idx_q           <= idx_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      disp_q          <= disp_d;
      an_q            <= an_d;
      seg_q           <= seg_d;
      digit_idx_q     <= digit_idx_d;
      frame_tick_q    <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign digit_idx  = digit_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_result_display.sv
// Bench for seg7_result_display: scenario tasks plus random traffic against a cycle-count reference model.
module tb_seg7_result_display;

  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = 4 * RD;
  localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        blank_en = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seg7_result_display #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .blank_en(blank_en),
    .an(an), .seg(seg), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: position in the scan follows from the number of edges since reset release.
  int          t;
  logic [15:0] m_disp, m_pend;
  logic        m_pv;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic [1:0]  exp_idx;
  logic        exp_tick;

  function automatic logic [6:0] model_seg(input logic [15:0] d, input int slot, input logic be);
    logic [15:0] upper;
    upper = d >> (4 * slot);
    if (be && slot > 0 && upper == 16'h0000) return 7'h7F;
    return FONT[int'(upper & 16'h000F)];
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t <= 0; m_disp <= 16'h0; m_pend <= 16'h0; m_pv <= 1'b0;
      exp_an <= 4'hF; exp_seg <= 7'h7F; exp_idx <= 2'd0; exp_tick <= 1'b0;
    end else begin
      exp_idx  <= 2'((t / RD) % 4);
      exp_an   <= ((t % RD) < GD) ? 4'hF : 4'(~(4'b0001 << ((t / RD) % 4)));
      exp_seg  <= model_seg(m_disp, (t / RD) % 4, blank_en);
      exp_tick <= ((t % FRAME) == FRAME - 1);
      if (load && (t % FRAME) == FRAME - 1) begin
        m_disp <= value; m_pv <= 1'b0;
      end else if (load) begin
        m_pend <= value; m_pv <= 1'b1;
      end else if ((t % FRAME) == FRAME - 1 && m_pv) begin
        m_disp <= m_pend; m_pv <= 1'b0;
      end
      t <= t + 1;
    end
  end

  // Idle until the next rising edge will be processed at frame position pos.
  task automatic advance_to(input int pos);
    for (int i = 0; i <= FRAME && (t % FRAME) != pos; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    load = 1'b1; value = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, digit_idx, frame_tick} !== {4'hF, 7'h7F, 2'd0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc=%0d got an=%b seg=%h idx=%0d tick=%b want an=1111 seg=7f idx=0 tick=0",
                 i, an, seg, digit_idx, frame_tick);
      end
    end
    reset = 1'b1; load = 1'b1; value = 16'h1234;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_scan();
    int low_cnt [4];
    int last_tick;
    int exp2 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    low_cnt = '{0, 0, 0, 0};
    last_tick = -1;
    while (t < 2 * FRAME + 1) begin
      checks++;
      if ({an, seg, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_idx, exp_tick}) begin
        errors++;
        $display("[TB] FAIL scan t=%0d got an=%b seg=%h idx=%0d tick=%b want an=%b seg=%h idx=%0d tick=%b",
                 t, an, seg, digit_idx, frame_tick, exp_an, exp_seg, exp_idx, exp_tick);
      end
      for (int d = 0; d < 4; d++) if (an === 4'(~(4'b0001 << d))) low_cnt[d]++;
      if (an !== 4'hF) begin
        checks++;
        if (t <= FRAME && seg !== 7'h40) begin
          errors++;
          $display("[TB] FAIL scan_frame1 t=%0d got seg=%h want 40", t, seg);
        end else if (t > FRAME && seg !== 7'(exp2[digit_idx])) begin
          errors++;
          $display("[TB] FAIL scan_frame2 t=%0d digit=%0d got seg=%h want %h", t, digit_idx, seg, exp2[digit_idx]);
        end
      end
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          checks++;
          if (t - last_tick != FRAME) begin
            errors++;
            $display("[TB] FAIL tick_period got %0d want %0d", t - last_tick, FRAME);
          end
        end
        last_tick = t;
      end
      @(negedge clk);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (low_cnt[d] != 2 * (RD - GD)) begin
        errors++;
        $display("[TB] FAIL anode_low digit=%0d got %0d want %0d", d, low_cnt[d], 2 * (RD - GD));
      end
    end
    checks++;
    if (last_tick != 2 * FRAME) begin
      errors++;
      $display("[TB] FAIL tick_time got %0d want %0d", last_tick, 2 * FRAME);
    end
  endtask

  task automatic test_deferred();
    advance_to(RD + 3);
    load = 1'b1; value = 16'hABCD;
    @(negedge clk);
    load = 1'b0;
    advance_to(2 * RD + 1);
    load = 1'b1; value = 16'h00EF;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_idx, exp_tick}) begin
        errors++;
        $display("[TB] FAIL deferred t=%0d got an=%b seg=%h idx=%0d tick=%b want an=%b seg=%h idx=%0d tick=%b",
                 t, an, seg, digit_idx, frame_tick, exp_an, exp_seg, exp_idx, exp_tick);
      end
      checks++;
      if (an !== 4'hF && (seg === 7'h08 || seg === 7'h03 || seg === 7'h46 || seg === 7'h21)) begin
        errors++;
        $display("[TB] FAIL deferred_abcd t=%0d got seg=%h want no A/b/C/d glyph", t, seg);
      end
    end
  endtask

  task automatic test_boundary_load();
    logic [6:0] want [4] = '{7'h08, 7'h12, 7'h08, 7'h12};
    advance_to(FRAME - 1);
    load = 1'b1; value = 16'h5A5A;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_idx, exp_tick}) begin
        errors++;
        $display("[TB] FAIL boundary t=%0d got an=%b seg=%h idx=%0d tick=%b want an=%b seg=%h idx=%0d tick=%b",
                 t, an, seg, digit_idx, frame_tick, exp_an, exp_seg, exp_idx, exp_tick);
      end
      if (an !== 4'hF) begin
        checks++;
        if (seg !== want[digit_idx]) begin
          errors++;
          $display("[TB] FAIL boundary_5a5a t=%0d digit=%0d got seg=%h want %h", t, digit_idx, seg, want[digit_idx]);
        end
      end
    end
  endtask

  task automatic test_blanking();
    advance_to(FRAME - 1);
    load = 1'b1; value = 16'h0007; blank_en = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (i == FRAME) blank_en = 1'b0;
      checks++;
      if ({an, seg, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_idx, exp_tick}) begin
        errors++;
        $display("[TB] FAIL blank t=%0d got an=%b seg=%h idx=%0d tick=%b want an=%b seg=%h idx=%0d tick=%b",
                 t, an, seg, digit_idx, frame_tick, exp_an, exp_seg, exp_idx, exp_tick);
      end
      if (an !== 4'hF) begin
        checks++;
        if (digit_idx == 2'd0 && seg !== 7'h78) begin
          errors++;
          $display("[TB] FAIL blank_digit0 t=%0d got seg=%h want 78", t, seg);
        end else if (digit_idx != 2'd0 && i <= FRAME && seg !== 7'h7F) begin
          errors++;
          $display("[TB] FAIL blank_on t=%0d digit=%0d got seg=%h want 7f", t, digit_idx, seg);
        end else if (digit_idx != 2'd0 && i > FRAME && seg !== 7'h40) begin
          errors++;
          $display("[TB] FAIL blank_off t=%0d digit=%0d got seg=%h want 40", t, digit_idx, seg);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    advance_to(2);
    load = 1'b1; value = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    advance_to(2 * RD + 3);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({an, seg, digit_idx, frame_tick} !== {4'hF, 7'h7F, 2'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_async got an=%b seg=%h idx=%0d tick=%b want an=1111 seg=7f idx=0 tick=0",
               an, seg, digit_idx, frame_tick);
    end
    @(negedge clk);
    checks++;
    if ({an, seg, digit_idx, frame_tick} !== {4'hF, 7'h7F, 2'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_held got an=%b seg=%h idx=%0d tick=%b want reset values", an, seg, digit_idx, frame_tick);
    end
    reset = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_idx, exp_tick}) begin
        errors++;
        $display("[TB] FAIL reset_mid t=%0d got an=%b seg=%h idx=%0d tick=%b want an=%b seg=%h idx=%0d tick=%b",
                 t, an, seg, digit_idx, frame_tick, exp_an, exp_seg, exp_idx, exp_tick);
      end
      if (an !== 4'hF) begin
        checks++;
        if (seg !== 7'h40) begin
          errors++;
          $display("[TB] FAIL reset_lost_pending t=%0d got seg=%h want 40", t, seg);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({an, seg, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_idx, exp_tick}) begin
        errors++;
        $display("[TB] FAIL random t=%0d got an=%b seg=%h idx=%0d tick=%b want an=%b seg=%h idx=%0d tick=%b",
                 t, an, seg, digit_idx, frame_tick, exp_an, exp_seg, exp_idx, exp_tick);
      end
      load  = ($urandom % 6) == 0;
      value = 16'($urandom) >> (4 * ($urandom % 4));
      if (($urandom % 16) == 0) blank_en = ~blank_en;
    end
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_deferred();
    test_boundary_load();
    test_blanking();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
